vga_timing_ctrl: RTL and testbench

Display-side timing master for the Sudoku VGA path. It generates the 25 MHz pixel enable from the 100 MHz system clock and runs the 640x480@60 horizontal and vertical counters. The `h_cnt`/`v_cnt` coordinates drive the game pixel generator. The 12-bit colour returned by that generator is registered onto the VGA pins, with hsync/vsync delayed to match so colour and sync stay pixel-aligned.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing_ctrl_clk_en_div.sv | 34 +++
 rtl/vga_timing_ctrl.sv | 122 ++++++++++++
 tb/tb_vga_timing_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, RGB444 colour type and a window-decode helper
// for the VGA display path.
package vga_pkg;

  localparam int CNT_W = 10;
  localparam int RGB_W = 12;

  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;

  localparam logic [RGB_W-1:0] BLACK = 12'h000;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Inclusive window test used for the active-low sync pulses.
  function automatic logic in_range(input logic [CNT_W-1:0] x,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_clk_en_div.sv
// Pixel-enable divider: one registered pix_en pulse every CLK_DIV enabled clocks.
// pix_tick is the same event one clock earlier, so counters can load on the edge that raises pix_en.
module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_tick,
  output logic pix_en
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             pix_q;

  assign pix_tick = en && (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      pix_q <= 1'b0;
    end else begin
      pix_q <= pix_tick;
      if (en) div_q <= pix_tick ? '0 : div_q + 1'b1;
    end
  end

  // A pulse already in flight is suppressed while the controller is paused.
  assign pix_en = pix_q & en;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing master: pixel-enable divider, h/v raster counters, sync decode and a
// pixel-aligned registered colour/sync output stage.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [RGB_W-1:0] pixel_in,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             valid,
  output logic             frame_start,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             hsync,
  output logic             vsync
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

  logic    pix_tick;
  logic    h_wrap;
  logic    v_wrap;
  logic    hs_c;
  logic    vs_c;
  logic    vld_p1;
  logic    hs_p1;
  logic    vs_p1;
  rgb444_t rgb_p2;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_en_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pix_tick (pix_tick),
    .pix_en   (pix_en)
  );

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Stage p0: raster counters load on the edge that raises pix_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && h_wrap && v_wrap;
      if (pix_tick) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign valid = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hs_c  = !in_range(h_cnt, HS_FIRST, HS_LAST);
  assign vs_c  = !in_range(v_cnt, VS_FIRST, VS_LAST);

  // Stage p1: capture the decode of the coordinate the generator is now fetching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else if (pix_en) begin
      vld_p1 <= valid;
      hs_p1  <= hs_c;
      vs_p1  <= vs_c;
    end
  end

  // Stage p2: pins update together with the next counter step, one pixel behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2 <= rgb444_t'(BLACK);
      hsync  <= 1'b1;
      vsync  <= 1'b1;
    end else if (!en) begin
      rgb_p2 <= rgb444_t'(BLACK);
    end else if (pix_tick) begin
      rgb_p2 <= vld_p1 ? rgb444_t'(pixel_in) : rgb444_t'(BLACK);
      hsync  <= hs_p1;
      vsync  <= vs_p1;
    end
  end

  assign vga_r = rgb_p2.r;
  assign vga_g = rgb_p2.g;
  assign vga_b = rgb_p2.b;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomised bench for vga_timing_ctrl on a shrunken raster, checked every clock
// against a pixel-index reference model.
module tb_vga_timing_ctrl;

  localparam int CLK_DIV = 4;
  localparam int H_VIS = 16, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_VIS = 6,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int HT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [11:0] pixel_in;
  logic        pix_en;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic        frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync;

  vga_timing_ctrl #(
    .CLK_DIV (CLK_DIV),
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pixel_in    (pixel_in),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid       (valid),
    .frame_start (frame_start),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .hsync       (hsync),
    .vsync       (vsync)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: raster position follows from enabled clocks since reset.
  int          m_ecnt;
  bit          m_tick;
  bit          m_fresh;
  bit          m_fs;
  bit          m_hs;
  bit          m_vs;
  logic [11:0] m_rgb;
  int          clk_since_rst;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
  endtask

  function automatic int cur_p();
    return (m_ecnt / CLK_DIV) % FRAME;
  endfunction
  function automatic int cur_h();
    return cur_p() % HT;
  endfunction
  function automatic int cur_v();
    return cur_p() / HT;
  endfunction

  task automatic model_reset();
    m_ecnt = 0; m_tick = 0; m_fresh = 1; m_fs = 0;
    m_hs = 1; m_vs = 1; m_rgb = 12'h000; clk_since_rst = 0;
  endtask

  task automatic model_edge();
    bit tick;
    int p, ph, pv;
    tick = 0;
    if (en) begin
      m_ecnt++;
      tick = (m_ecnt % CLK_DIV) == 0;
    end
    if (!en) m_rgb = 12'h000;
    else if (tick) begin
      p  = (m_ecnt / CLK_DIV - 1) % FRAME;
      ph = p % HT;
      pv = p / HT;
      if (m_fresh) begin
        m_rgb = 12'h000; m_hs = 1; m_vs = 1;
      end else begin
        m_rgb = (ph < H_VIS && pv < V_VIS) ? pixel_in : 12'h000;
        m_hs  = !(ph >= H_VIS + H_FP && ph < H_VIS + H_FP + H_SYNC);
        m_vs  = !(pv >= V_VIS + V_FP && pv < V_VIS + V_FP + V_SYNC);
      end
      m_fresh = 0;
    end
    m_fs   = tick && (((m_ecnt / CLK_DIV) % FRAME) == 0);
    m_tick = tick;
    clk_since_rst++;
  endtask

  task automatic check_all();
    int hh, vv;
    hh = cur_h();
    vv = cur_v();
    check_eq("h_cnt",       int'(h_cnt),       hh);
    check_eq("v_cnt",       int'(v_cnt),       vv);
    check_eq("valid",       int'(valid),       int'(hh < H_VIS && vv < V_VIS));
    check_eq("pix_en",      int'(pix_en),      int'(m_tick && en));
    check_eq("frame_start", int'(frame_start), int'(m_fs));
    check_eq("rgb",         int'({vga_r, vga_g, vga_b}), int'(m_rgb));
    check_eq("hsync",       int'(hsync),       int'(m_hs));
    check_eq("vsync",       int'(vsync),       int'(m_vs));
    if (m_fs) begin
      check_eq("wrap_hv",    int'(h_cnt) + int'(v_cnt), 0);
      check_eq("wrap_valid", int'(valid), 1);
    end
  endtask

  // mode 0: en held high, 1: random en drops, 2: en held low (never inside a pix_en cycle)
  task automatic step(input int mode, input bit pat);
    int hh, vv;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    hh = cur_h();
    vv = cur_v();
    if (m_tick || mode == 0) en = 1'b1;
    else if (mode == 1)      en = ($urandom_range(0, 5) != 0);
    else                     en = 1'b0;
    pixel_in = pat ? {4'(hh), 4'(vv), 4'h5} : 12'($urandom());
    @(negedge clk);
    if (rst_n) check_all();
  endtask

  task automatic run_to(input int th, input int tv);
    int k;
    k = 0;
    while (!(m_tick && cur_h() == th && cur_v() == tv) && k < 3000) begin
      step(0, 0);
      k++;
    end
    check_eq("reach_coord", int'(k < 3000), 1);
  endtask

  task automatic run_to_frame_start(input string tag);
    int k;
    k = 0;
    do begin
      step(0, 0);
      k++;
    end while (!frame_start && k < FRAME * CLK_DIV + 20);
    check_eq(tag, clk_since_rst, FRAME * CLK_DIV);
  endtask

  initial begin
    int k;
    rst_n = 1'b1; en = 1'b0; pixel_in = 12'h000;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;

    // Full first frame with en held high and random colour.
    run_to_frame_start("first_frame_clks");

    // Random en drops and random colour.
    for (int i = 0; i < 1200; i++) step(1, 0);

    // Coordinate-derived colour for one full frame.
    for (int i = 0; i < FRAME * CLK_DIV + 40; i++) step(0, 1);

    // Pause at (10,3) for 50 clocks, then resume.
    run_to(10, 3);
    step(2, 0);
    step(2, 0);
    check_eq("drop_rgb", int'({vga_r, vga_g, vga_b}), 0);
    for (int i = 0; i < 48; i++) step(2, 0);
    check_eq("hold_h", int'(h_cnt), 10);
    check_eq("hold_v", int'(v_cnt), 3);
    k = 0;
    do begin
      step(0, 0);
      k++;
    end while (!pix_en && k < 10);
    check_eq("resume_h", int'(h_cnt), 11);
    check_eq("resume_v", int'(v_cnt), 3);

    // Asynchronous reset in the middle of hsync.
    run_to(19, 4);
    check_eq("pre_rst_hsync", int'(hsync), 0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_h",     int'(h_cnt), 0);
    check_eq("rst_v",     int'(v_cnt), 0);
    check_eq("rst_hsync", int'(hsync), 1);
    check_eq("rst_rgb",   int'({vga_r, vga_g, vga_b}), 0);
    check_eq("rst_valid", int'(valid), 1);
    check_eq("rst_pix",   int'(pix_en), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;
    run_to_frame_start("post_rst_frame_clks");
    for (int i = 0; i < 200; i++) step(1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
